// File: rtl/pwm_compare_counter_pkg.sv
// pwm_compare_counter_pkg: shared width, reset constants and load-pair type
package pwm_compare_counter_pkg;
  localparam int PWM_WIDTH = 2;
  typedef logic [PWM_WIDTH-1:0] pwm_val_t;
  localparam pwm_val_t PERIOD_RST = '1;
  localparam pwm_val_t DUTY_RST = '0;
  typedef struct packed {
    pwm_val_t period;
    pwm_val_t duty;
  } pwm_pair_t;
endpackage

// File: rtl/pwm_wrap_counter.sv
// pwm_wrap_counter: free-running period counter with terminal detect and registered wrap pulse
module pwm_wrap_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic [W-1:0] cnt,
  output logic         wrap_now,
  output logic         wrap
);
  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap_q, wrap_d;
  always_comb begin
    wrap_now = cnt_q == period;
    cnt_d    = en ? (wrap_now ? '0 : cnt_q + 1'b1) : cnt_q;
    wrap_d   = en & wrap_now;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end
  assign cnt  = cnt_q;
  assign wrap = wrap_q;
endmodule

// File: rtl/pwm_compare_counter.sv
// pwm_compare_counter: PWM generator driving an external unsigned >= comparator,
// with period/duty double-buffered and applied only at period wrap.
import pwm_compare_counter_pkg::*;
module pwm_compare_counter (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  logic     ld_valid,
  output logic     ld_ready,
  input  pwm_val_t ld_period,
  input  pwm_val_t ld_duty,
  output pwm_val_t cmp_i0,
  output pwm_val_t cmp_i1,
  input  logic     cmp_ge,
  output logic     pwm,
  output logic     wrap
);
  pwm_pair_t pend_q, pend_d, act_q, act_d;
  logic      pend_valid_q, pend_valid_d;
  logic      pwm_q, pwm_d;
  logic      wrap_now, accept, apply;
  pwm_val_t  cnt;
  pwm_wrap_counter #(.W(PWM_WIDTH)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .period   (act_q.period),
    .cnt      (cnt),
    .wrap_now (wrap_now),
    .wrap     (wrap)
  );
  // accept only sees an empty slot, so a pair taken on a wrap edge waits for the next wrap
  always_comb begin
    accept       = ld_valid & ~pend_valid_q;
    apply        = en & wrap_now & pend_valid_q;
    pend_d       = accept ? '{period: ld_period, duty: ld_duty} : pend_q;
    pend_valid_d = accept | (pend_valid_q & ~apply);
    act_d        = apply ? pend_q : act_q;
    pwm_d        = en ? ~cmp_ge : pwm_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= '{period: PERIOD_RST, duty: DUTY_RST};
      act_q        <= '{period: PERIOD_RST, duty: DUTY_RST};
      pend_valid_q <= 1'b0;
      pwm_q        <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      act_q        <= act_d;
      pend_valid_q <= pend_valid_d;
      pwm_q        <= pwm_d;
    end
  end
  assign ld_ready = ~pend_valid_q;
  assign cmp_i0   = cnt;
  assign cmp_i1   = act_q.duty;
  assign pwm      = pwm_q;
endmodule

// File: tb/tb_pwm_compare_counter.sv
// tb_pwm_compare_counter: closes the comparator loop and checks the DUT against a behavioural model
module tb_pwm_compare_counter;
  import pwm_compare_counter_pkg::*;
  logic     clk = 0, rst_n = 0, en = 0, ld_valid = 0, cmp_ge, ld_ready, pwm, wrap;
  pwm_val_t ld_period = '0, ld_duty = '0, cmp_i0, cmp_i1;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign cmp_ge = cmp_i0 >= cmp_i1;
  pwm_compare_counter dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_period(ld_period), .ld_duty(ld_duty), .cmp_i0(cmp_i0), .cmp_i1(cmp_i1),
    .cmp_ge(cmp_ge), .pwm(pwm), .wrap(wrap)
  );
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  // Model: period length is per+1, output high while count < duty, new pair waits for a wrap after it was taken
  pwm_val_t m_cnt, m_per, m_duty, m_pp, m_pd;
  logic     m_pv, m_pwm, m_wrap;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_per <= 3; m_duty <= 0; m_pv <= 0; m_pwm <= 0; m_wrap <= 0;
    end else begin
      if (en) begin
        m_cnt  <= (int'(m_cnt) == int'(m_per)) ? pwm_val_t'(0) : pwm_val_t'((int'(m_cnt) + 1) % 4);
        m_pwm  <= int'(m_cnt) < int'(m_duty);
        m_wrap <= int'(m_cnt) == int'(m_per);
        if (int'(m_cnt) == int'(m_per) && m_pv) begin
          m_per <= m_pp; m_duty <= m_pd;
        end
      end else m_wrap <= 0;
      if (ld_valid && !m_pv) begin
        m_pv <= 1; m_pp <= ld_period; m_pd <= ld_duty;
      end else if (en && int'(m_cnt) == int'(m_per) && m_pv) m_pv <= 0;
    end
  end
  always @(negedge clk) if (rst_n) begin
    chk("model_cnt", cmp_i0, m_cnt);
    chk("model_duty", cmp_i1, m_duty);
    chk("model_pwm", pwm, m_pwm);
    chk("model_wrap", wrap, m_wrap);
    chk("model_ready", ld_ready, !m_pv);
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic offer(input int p, input int d);
    ld_period = pwm_val_t'(p); ld_duty = pwm_val_t'(d); ld_valid = 1;
  endtask
  task automatic wait_i1(input int v, input string n);
    int k = 0;
    while (int'(cmp_i1) != v && k < 16) begin step(1); k++; end
    chk(n, cmp_i1, v);
  endtask
  task automatic wait_i0(input int v, input string n);
    int k = 0;
    while (int'(cmp_i0) != v && k < 16) begin step(1); k++; end
    chk(n, cmp_i0, v);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int p;
    #3;
    chk("rst_cnt", cmp_i0, 0); chk("rst_duty", cmp_i1, 0); chk("rst_pwm", pwm, 0);
    chk("rst_wrap", wrap, 0); chk("rst_ready", ld_ready, 1);
    step(2);
    rst_n = 1; en = 1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("t1_cnt", cmp_i0, (i + 1) % 4);
      chk("t1_wrap", wrap, ((i + 1) % 4) == 0);
      chk("t1_pwm", pwm, 0);
    end
    offer(3, 1); step(1); ld_valid = 0;
    chk("t2_ready_low", ld_ready, 0);
    wait_i1(1, "t2_apply");
    chk("t2_ready_high", ld_ready, 1);
    chk("t2_cnt0", cmp_i0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk("t2_pwm", pwm, ((k - 1) % 4) == 0);
    end
    offer(2, 3); step(1); ld_valid = 0;
    wait_i1(3, "t3_apply");
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk("t3_pwm", pwm, 1);
      chk("t3_cnt", cmp_i0, k % 3);
    end
    offer(0, 1); step(1); ld_valid = 0;
    wait_i1(1, "t3b_apply");
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("t3b_wrap", wrap, 1); chk("t3b_cnt", cmp_i0, 0); chk("t3b_pwm", pwm, 1);
    end
    offer(3, 2); step(1); ld_valid = 0;
    wait_i1(2, "t4_pre");
    wait_i0(3, "t4_at_wrap");
    offer(1, 1); step(1); ld_valid = 0;
    chk("t4_cnt0", cmp_i0, 0); chk("t4_not_applied", cmp_i1, 2); chk("t4_accepted", ld_ready, 0);
    step(3);
    chk("t4_cnt3", cmp_i0, 3); chk("t4_old_duty", cmp_i1, 2);
    step(1);
    chk("t4_cnt_wrap", cmp_i0, 0); chk("t4_new_duty", cmp_i1, 1);
    step(1); chk("t4_new_per1", cmp_i0, 1);
    step(1); chk("t4_new_per0", cmp_i0, 0);
    offer(3, 3); step(1);
    chk("t5_a_taken", ld_ready, 0);
    offer(2, 1);
    wait_i1(3, "t5_a_apply");
    chk("t5_ready_at_apply", ld_ready, 1);
    step(1); ld_valid = 0;
    chk("t5_b_taken", ld_ready, 0);
    wait_i1(1, "t5_b_apply");
    chk("t5_ready_end", ld_ready, 1);
    wait_i0(1, "t6_mid");
    en = 0; p = pwm;
    step(3);
    chk("t6_frozen_cnt", cmp_i0, 1); chk("t6_frozen_pwm", pwm, p); chk("t6_no_wrap", wrap, 0);
    en = 1;
    offer(3, 3); step(1); ld_valid = 0;
    chk("t6_pending", ld_ready, 0);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_cnt", cmp_i0, 0); chk("t6_rst_pwm", pwm, 0); chk("t6_rst_ready", ld_ready, 1);
    chk("t6_rst_duty", cmp_i1, 0); chk("t6_rst_wrap", wrap, 0);
    step(2);
    rst_n = 1;
    step(8);
    chk("t6_discarded", cmp_i1, 0); chk("t6_pwm_off", pwm, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
